spi_flash_emu: RTL and testbench

//  Parametrised SPI NOR flash emulator between the byte-level SPI slave and the SDRAM arbiter.

---
 rtl/spi_flash_pkg.sv | 28 ++
 rtl/spi_flash_log_reg.sv | 47 ++++
 rtl/spi_flash_emu.sv | 215 +++++++++++++++++++++
 tb/tb_spi_flash_emu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash emulator: opcodes, FSM state
// encoding and the address-width mask helper.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ        = 8'h03;
  localparam logic [7:0] OP_FAST_READ   = 8'h0B;
  localparam logic [7:0] OP_READ4       = 8'h13;
  localparam logic [7:0] OP_JEDEC_ID    = 8'h9F;
  localparam logic [7:0] OP_READ_STATUS = 8'h05;
  localparam logic [7:0] OP_EN4B        = 8'hB7;
  localparam logic [7:0] OP_EX4B        = 8'hE9;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DUMMY, ST_DATA, ST_ID, ST_STAT, ST_IGNORE
  } state_t;

  // Mask keeping the low n address bytes; n >= 4 keeps the full word.
  function automatic logic [31:0] addr_mask(input logic [2:0] n);
    case (n)
      3'd0:    return 32'h0000_0000;
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      3'd3:    return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_log_reg.sv
// Log record for completed reads.
// Ports: clear/opcode start a new record; addr_shift/shift_byte/mask build
// the start address; len_inc counts data bytes (saturating); underrun_set
// flags a late SDRAM return; emit produces the one-cycle log_strobe.
module spi_flash_log_reg #(
  parameter int LOG_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [7:0]           opcode,
  input  logic                 addr_shift,
  input  logic [7:0]           shift_byte,
  input  logic [31:0]          mask,
  input  logic                 len_inc,
  input  logic                 underrun_set,
  input  logic                 emit,
  output logic [31:0]          log_addr,
  output logic [LOG_LEN_W-1:0] log_len,
  output logic [7:0]           log_cmd,
  output logic                 log_underrun,
  output logic                 log_strobe
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      log_addr     <= '0;
      log_len      <= '0;
      log_cmd      <= '0;
      log_underrun <= 1'b0;
      log_strobe   <= 1'b0;
    end else begin
      log_strobe <= emit;
      if (clear) begin
        log_addr     <= '0;
        log_len      <= '0;
        log_underrun <= 1'b0;
        log_cmd      <= opcode;
      end else begin
        if (addr_shift) log_addr <= {log_addr[23:0], shift_byte} & mask;
        if (len_inc && log_len != '1) log_len <= log_len + 1'b1;
        if (underrun_set) log_underrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_flash_emu.sv
// SPI NOR flash emulator sitting between a byte-level SPI slave and the
// SDRAM arbiter. Decodes READ/FAST_READ/READ4/JEDEC ID/READ STATUS/EN4B/EX4B,
// streams SDRAM bytes to the SPI transmitter and logs every completed read.
// Ports: spi_* is the SPI byte interface (spi_cs high = deselected),
// ram_* is the SDRAM read port, log_* is the per-read log record.
module spi_flash_emu
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_BYTES_RST = 3,
  parameter int          LOG_LEN_W      = 16,
  parameter logic [23:0] JEDEC_ID       = 24'hEF4018,
  parameter logic [7:0]  STATUS_VAL     = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_cs,
  input  logic [7:0]           spi_rx_data,
  input  logic                 spi_rx_cmd,
  input  logic                 spi_rx_strobe,
  output logic                 spi_tx_strobe,
  output logic [7:0]           spi_tx_data,
  output logic                 spi_critical,
  output logic [31:0]          ram_addr,
  output logic                 ram_read_enable,
  input  logic [7:0]           ram_read_data,
  input  logic                 ram_read_valid,
  output logic [31:0]          log_addr,
  output logic [LOG_LEN_W-1:0] log_len,
  output logic [7:0]           log_cmd,
  output logic                 log_underrun,
  output logic                 log_strobe
);

  state_t      state, state_nx;
  logic        cs_q, cs_rise;
  logic        four_b;                 // current address mode is 4 bytes
  logic        mode_req_v, mode_req_4; // EN4B/EX4B waiting for deselect
  logic [2:0]  addr_n, addr_n_nx;      // address bytes of this read
  logic [2:0]  addr_left, addr_left_nx;
  logic [2:0]  out_cnt, cnt_nx;        // SDRAM reads issued, not yet returned
  logic        pending;
  logic [1:0]  id_idx, id_nx;
  logic        tx_q_strobe, tx_nx_stb, tx_c;
  logic [7:0]  tx_q_data, tx_nx_data;
  logic        crit_nx, clear, issue, addr_shift, data_stb, under_set, log_emit;
  logic [31:0] mask;

  function automatic logic [7:0] id_byte(input logic [1:0] i);
    case (i)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      2'd2:    return JEDEC_ID[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign cs_rise = spi_cs & ~cs_q;
  assign pending = (out_cnt != 3'd0);
  assign mask    = addr_mask(addr_n);

  // SDRAM data passes straight through in the cycle it returns; ID/status
  // bytes come from a register one cycle after the triggering byte.
  assign spi_tx_strobe = tx_q_strobe | tx_c;
  assign spi_tx_data   = tx_c ? ram_read_data : tx_q_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    crit_nx      = spi_critical;
    clear        = 1'b0;
    issue        = 1'b0;
    addr_shift   = 1'b0;
    data_stb     = 1'b0;
    under_set    = 1'b0;
    log_emit     = 1'b0;
    addr_n_nx    = addr_n;
    addr_left_nx = addr_left;
    id_nx        = id_idx;
    tx_nx_stb    = 1'b0;
    tx_nx_data   = 8'h00;
    tx_c         = 1'b0;
    if (spi_cs) begin
      state_nx = ST_IDLE;
      crit_nx  = 1'b0;
      log_emit = cs_rise && (state == ST_DATA);
    end else if (spi_rx_cmd) begin
      clear     = 1'b1;
      crit_nx   = 1'b0;
      addr_n_nx = four_b ? 3'd4 : 3'd3;
      case (spi_rx_data)
        OP_READ, OP_FAST_READ: begin state_nx = ST_ADDR; crit_nx = 1'b1; end
        OP_READ4: begin
          state_nx  = ST_ADDR;
          crit_nx   = 1'b1;
          addr_n_nx = 3'd4;
        end
        OP_JEDEC_ID: begin
          state_nx   = ST_ID;
          tx_nx_stb  = 1'b1;
          tx_nx_data = id_byte(2'd0);
          id_nx      = 2'd1;
        end
        OP_READ_STATUS: begin
          state_nx   = ST_STAT;
          tx_nx_stb  = 1'b1;
          tx_nx_data = STATUS_VAL;
        end
        default: state_nx = ST_IGNORE;
      endcase
      addr_left_nx = addr_n_nx;
    end else if (spi_rx_strobe) begin
      case (state)
        ST_ADDR: begin
          addr_shift   = 1'b1;
          addr_left_nx = addr_left - 3'd1;
          if (addr_left == 3'd1) begin
            if (log_cmd == OP_FAST_READ) state_nx = ST_DUMMY;
            else begin
              state_nx = ST_DATA;
              issue    = 1'b1;
            end
          end
        end
        ST_DUMMY: begin state_nx = ST_DATA; issue = 1'b1; end
        ST_DATA: begin
          data_stb  = 1'b1;
          issue     = 1'b1;
          under_set = pending;
        end
        ST_ID: begin
          tx_nx_stb  = 1'b1;
          tx_nx_data = id_byte(id_idx);
          if (id_idx != 2'd3) id_nx = id_idx + 2'd1;
        end
        ST_STAT: begin tx_nx_stb = 1'b1; tx_nx_data = STATUS_VAL; end
        default: ;
      endcase
    end else if (ram_read_valid && state == ST_DATA && out_cnt == 3'd1) begin
      // Only the newest outstanding read is forwarded; older returns after
      // an underrun arrive while out_cnt > 1 and are dropped.
      tx_c = 1'b1;
    end
  end

  always_comb begin
    cnt_nx = out_cnt;
    if (spi_cs) cnt_nx = 3'd0;
    else begin
      if (issue && out_cnt != 3'd7) cnt_nx = cnt_nx + 3'd1;
      if (ram_read_valid && out_cnt != 3'd0) cnt_nx = cnt_nx - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_critical    <= 1'b0;
      ram_read_enable <= 1'b0;
      ram_addr        <= '0;
      out_cnt         <= '0;
      addr_n          <= 3'd3;
      addr_left       <= '0;
      id_idx          <= '0;
      tx_q_strobe     <= 1'b0;
      tx_q_data       <= '0;
      cs_q            <= 1'b1;
      four_b          <= (ADDR_BYTES_RST == 4);
      mode_req_v      <= 1'b0;
      mode_req_4      <= 1'b0;
    end else begin
      spi_critical    <= crit_nx;
      ram_read_enable <= issue;
      out_cnt         <= cnt_nx;
      addr_n          <= addr_n_nx;
      addr_left       <= addr_left_nx;
      id_idx          <= id_nx;
      tx_q_strobe     <= tx_nx_stb;
      tx_q_data       <= tx_nx_data;
      cs_q            <= spi_cs;
      if (clear)           ram_addr <= '0;
      else if (addr_shift) ram_addr <= {ram_addr[23:0], spi_rx_data} & mask;
      else if (data_stb)   ram_addr <= (ram_addr + 32'd1) & mask;
      // Address mode changes only once the EN4B/EX4B transaction is closed.
      if (spi_cs) begin
        if (cs_rise && mode_req_v && state == ST_IGNORE) four_b <= mode_req_4;
        mode_req_v <= 1'b0;
      end else if (spi_rx_cmd) begin
        mode_req_v <= (spi_rx_data == OP_EN4B) || (spi_rx_data == OP_EX4B);
        mode_req_4 <= (spi_rx_data == OP_EN4B);
      end
    end
  end

  spi_flash_log_reg #(.LOG_LEN_W(LOG_LEN_W)) u_log (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .opcode       (spi_rx_data),
    .addr_shift   (addr_shift),
    .shift_byte   (spi_rx_data),
    .mask         (mask),
    .len_inc      (data_stb),
    .underrun_set (under_set),
    .emit         (log_emit),
    .log_addr     (log_addr),
    .log_len      (log_len),
    .log_cmd      (log_cmd),
    .log_underrun (log_underrun),
    .log_strobe   (log_strobe)
  );

endmodule

// File: tb/tb_spi_flash_emu.sv
// Scoreboard bench for spi_flash_emu: directed SPI transactions push the
// expected tx bytes, SDRAM read addresses and log records into queues;
// negedge monitors pop and compare whenever the DUT presents them.
module tb_spi_flash_emu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_cs, spi_rx_cmd, spi_rx_strobe;
  logic [7:0]  spi_rx_data;
  logic        spi_tx_strobe;
  logic [7:0]  spi_tx_data;
  logic        spi_critical;
  logic [31:0] ram_addr;
  logic        ram_read_enable;
  logic [7:0]  ram_read_data;
  logic        ram_read_valid;
  logic [31:0] log_addr;
  logic [15:0] log_len;
  logic [7:0]  log_cmd;
  logic        log_underrun, log_strobe;

  spi_flash_emu dut (
    .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_rx_data(spi_rx_data),
    .spi_rx_cmd(spi_rx_cmd), .spi_rx_strobe(spi_rx_strobe),
    .spi_tx_strobe(spi_tx_strobe), .spi_tx_data(spi_tx_data),
    .spi_critical(spi_critical), .ram_addr(ram_addr),
    .ram_read_enable(ram_read_enable), .ram_read_data(ram_read_data),
    .ram_read_valid(ram_read_valid), .log_addr(log_addr), .log_len(log_len),
    .log_cmd(log_cmd), .log_underrun(log_underrun), .log_strobe(log_strobe)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [15:0] l; logic [7:0] c; logic u; } log_t;
  logic [7:0]  tx_q[$];
  logic [31:0] rd_q[$];
  log_t        log_q[$];
  int n_run = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm, input logic [31:0] act);
    n_run++;
    n_fail++;
    $display("FAIL %s: got %h expected nothing", nm, act);
  endtask

  function automatic logic [7:0] dfun(input logic [31:0] a);
    return a[7:0] + 8'h11;
  endfunction

  // SDRAM model: data returns two cycles after the enable cycle.
  logic        en_s;
  logic [31:0] a_s;
  logic [1:0]  pv;
  logic [31:0] pa [2];
  always @(negedge clk) begin en_s <= ram_read_enable; a_s <= ram_addr; end
  initial begin
    ram_read_valid = 1'b0; ram_read_data = 8'h00; pv = 2'b00;
    pa[0] = '0; pa[1] = '0;
    forever begin
      @(posedge clk); #1;
      pv[1] = pv[0]; pa[1] = pa[0];
      pv[0] = en_s;  pa[0] = a_s;
      ram_read_valid = pv[1];
      ram_read_data  = pv[1] ? dfun(pa[1]) : 8'h00;
    end
  end

  // Monitors
  always @(negedge clk) begin
    if (spi_tx_strobe) begin
      if (tx_q.size() == 0) extra("tx_extra", {24'h0, spi_tx_data});
      else chk("tx_data", {24'h0, spi_tx_data}, {24'h0, tx_q.pop_front()});
    end else chk("tx_idle_zero", {24'h0, spi_tx_data}, 32'h0);
    if (ram_read_enable) begin
      if (rd_q.size() == 0) extra("read_extra", ram_addr);
      else chk("read_addr", ram_addr, rd_q.pop_front());
    end
    if (log_strobe) begin
      if (log_q.size() == 0) extra("log_extra", log_addr);
      else begin
        log_t e;
        e = log_q.pop_front();
        chk("log_addr", log_addr, e.a);
        chk("log_len", {16'h0, log_len}, {16'h0, e.l});
        chk("log_cmd", {24'h0, log_cmd}, {24'h0, e.c});
        chk("log_underrun", {31'h0, log_underrun}, {31'h0, e.u});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    if (spi_cs) begin @(posedge clk); #1 spi_cs = 1'b0; end
    @(posedge clk); #1 spi_rx_cmd = 1'b1; spi_rx_data = op;
    @(posedge clk); #1 spi_rx_cmd = 1'b0; spi_rx_data = 8'h00;
  endtask

  task automatic send_strb(input logic [7:0] b);
    @(posedge clk); #1 spi_rx_strobe = 1'b1; spi_rx_data = b;
    @(posedge clk); #1 spi_rx_strobe = 1'b0; spi_rx_data = 8'h00;
  endtask

  task automatic data_strobes(input int n);
    for (int i = 0; i < n; i++) begin idle(4); send_strb(8'h00); end
  endtask

  task automatic cs_rise(input logic exp_log);
    @(posedge clk); #1 spi_cs = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("cs_log_strobe", {31'h0, log_strobe}, {31'h0, exp_log});
    chk("cs_critical", {31'h0, spi_critical}, 32'h0);
    chk("cs_read_en", {31'h0, ram_read_enable}, 32'h0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_tx_strobe"}, {31'h0, spi_tx_strobe}, 32'h0);
    chk({pfx, "_tx_data"}, {24'h0, spi_tx_data}, 32'h0);
    chk({pfx, "_critical"}, {31'h0, spi_critical}, 32'h0);
    chk({pfx, "_ram_addr"}, ram_addr, 32'h0);
    chk({pfx, "_read_en"}, {31'h0, ram_read_enable}, 32'h0);
    chk({pfx, "_log_addr"}, log_addr, 32'h0);
    chk({pfx, "_log_len"}, {16'h0, log_len}, 32'h0);
    chk({pfx, "_log_cmd"}, {24'h0, log_cmd}, 32'h0);
    chk({pfx, "_log_strobe"}, {31'h0, log_strobe}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; spi_cs = 1'b1; spi_rx_cmd = 1'b0; spi_rx_strobe = 1'b0;
    spi_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: READ 123456, four data bytes, latency 2
    for (int i = 0; i < 5; i++) begin
      rd_q.push_back(32'h123456 + i);
      tx_q.push_back(dfun(32'h123456 + i));
    end
    log_q.push_back('{32'h123456, 16'd4, 8'h03, 1'b0});
    send_cmd(8'h03);
    @(negedge clk); chk("t1_critical", {31'h0, spi_critical}, 32'h1);
    send_strb(8'h12); send_strb(8'h34); send_strb(8'h56);
    data_strobes(4); idle(4); cs_rise(1'b1);

    // 2: FAST_READ 000010, read issued only after the dummy byte
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(32'h10 + i);
      tx_q.push_back(dfun(32'h10 + i));
    end
    log_q.push_back('{32'h10, 16'd2, 8'h0B, 1'b0});
    send_cmd(8'h0B);
    send_strb(8'h00); send_strb(8'h00); send_strb(8'h10);
    @(negedge clk); chk("t2_no_read_before_dummy", {31'h0, ram_read_enable}, 32'h0);
    send_strb(8'hA5);
    data_strobes(2); idle(4); cs_rise(1'b1);

    // 3: EN4B, then 4-byte READ at FFFFFFFF wrapping to 0
    send_cmd(8'hB7); cs_rise(1'b0);
    rd_q.push_back(32'hFFFF_FFFF); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
    tx_q.push_back(8'h10); tx_q.push_back(8'h11); tx_q.push_back(8'h12);
    log_q.push_back('{32'hFFFF_FFFF, 16'd2, 8'h03, 1'b0});
    send_cmd(8'h03);
    repeat (4) send_strb(8'hFF);
    data_strobes(2); idle(4); cs_rise(1'b1);

    // 4: JEDEC ID
    tx_q.push_back(8'hEF); tx_q.push_back(8'h40); tx_q.push_back(8'h18);
    tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    send_cmd(8'h9F);
    @(negedge clk); chk("t4_critical_cmd", {31'h0, spi_critical}, 32'h0);
    repeat (4) send_strb(8'h00);
    idle(2);
    @(negedge clk); chk("t4_critical_end", {31'h0, spi_critical}, 32'h0);
    cs_rise(1'b0);

    // 5: deselect mid-address, then READ STATUS
    send_cmd(8'h03);
    @(negedge clk); chk("t5_critical", {31'h0, spi_critical}, 32'h1);
    send_strb(8'hAB); send_strb(8'hCD);
    cs_rise(1'b0);
    tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    send_cmd(8'h05); send_strb(8'h00); idle(2); cs_rise(1'b0);

    // 6: reset with a read pending (address mode is 4 here)
    rd_q.push_back(32'h100);
    send_cmd(8'h03);
    send_strb(8'h00); send_strb(8'h00); send_strb(8'h01); send_strb(8'h00);
    @(negedge clk); chk("t6_read_issued", {31'h0, ram_read_enable}, 32'h1);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("t6_async");
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t6_late_valid_no_tx", {31'h0, spi_tx_strobe}, 32'h0);
    spi_cs = 1'b1; idle(2);
    // address mode back to 3 bytes after reset
    rd_q.push_back(32'h20); rd_q.push_back(32'h21);
    tx_q.push_back(8'h31); tx_q.push_back(8'h32);
    log_q.push_back('{32'h20, 16'd1, 8'h03, 1'b0});
    send_cmd(8'h03);
    send_strb(8'h00); send_strb(8'h00); send_strb(8'h20);
    data_strobes(1); idle(4); cs_rise(1'b1);

    // 7: strobe before the first byte returns -> underrun, stale byte dropped
    rd_q.push_back(32'h40); rd_q.push_back(32'h41);
    tx_q.push_back(8'h52);
    log_q.push_back('{32'h40, 16'd1, 8'h03, 1'b1});
    send_cmd(8'h03);
    send_strb(8'h00); send_strb(8'h00); send_strb(8'h40);
    send_strb(8'h00);
    idle(6); cs_rise(1'b1);

    idle(5);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("log_q_drained", log_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
